tmds_video_encoder: RTL and testbench
=====================================

# tmds_video_encoder

- Single-clock, pixel-rate TMDS encoder for three channels.
- Takes VGA-style pixel and sync input and produces the three 10-bit TMDS words per pixel clock.
- The words feed the team's 10:1 / 5:2 serializer stage.
- In HDMI mode it also inserts the video preamble and leading guard band before every active period, using a fixed look-ahead delay line; DVI mode emits plain control periods.

## Interface
- HDMI_MODE, 1, 1 = insert preamble and guard band; 0 = DVI (control codes only).
- PREAMBLE_LEN, 8, preamble slots before each active period (1..8).
- GUARD_LEN, 2, guard-band slots before each active period (1..2).
- pclk  input  1  pixel clock; all state on rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- in_vga_red / in_vga_green / in_vga_blue  input  8 each  pixel data.
- in_vga_blank  input  1  1 = blanking; active video is ~in_vga_blank.
- in_vga_vsync, in_vga_hsync  input  1 each  syncs; carried on the blue channel as {c1,c0} = {vsync,hsync}.
- out_tmds_red / out_tmds_green / out_tmds_blue  output  10 each  TMDS word; bit 0 is transmitted first.
- out_de  output  1  registered data-enable aligned with out_tmds_*.
- out_period  output  2  00 CTRL, 01 PREAMBLE, 10 GUARD, 11 VIDEO.

## Operation
- LA = PREAMBLE_LEN+GUARD_LEN.
- Delay line s[0..LA] holds {de, vsync, hsync, rgb}; s[0] is the registered input.
- The encoder works on slot s[LA].
- Slot classification, with j = smallest k in 1..LA where s[LA-k].de = 1:
  - s[LA].de = 1: VIDEO.
  - j exists and j ≤ GUARD_LEN: GUARD.
  - j exists and GUARD_LEN < j ≤ LA: PREAMBLE.
  - Otherwise: CTRL.
  - When HDMI_MODE = 0, PREAMBLE and GUARD become CTRL.
- Control code for {c1,c0}: 00→1101010100, 01→0010101011, 10→0101010100, 11→1010101011 (bit 9 left).
- CTRL:
  - Blue = code{vsync,hsync}.
  - Green = code 00.
  - Red = code 00.
- PREAMBLE:
  - Blue = code{vsync,hsync}.
  - Green = code 01 (CTL0 = 1).
  - Red = code 00.
- GUARD:
  - Blue = 1011001100.
  - Green = 0100110011.
  - Red = 1011001100.
- VIDEO: standard DVI 1.0 8b/10b encoding per channel.
  - Stage A:
    - n1 = number of ones in d.
    - XNOR path if n1 > 4, or if n1 = 4 and d[0] = 0; otherwise XOR path.
    - Produces 9-bit q_m.
  - Stage B uses a per-channel running disparity cnt, signed 5-bit, range -8..+8, always even.
    - If cnt = 0 or n1(q_m) = n0(q_m):
      - out = {~q_m8, q_m8, q_m8 ? q_m[7:0] : ~q_m[7:0]}.
      - cnt += q_m8 ? n1-n0 : n0-n1.
    - Else if (cnt > 0 and n1 > n0) or (cnt < 0 and n0 > n1):
      - out = {1, q_m8, ~q_m[7:0]}.
      - cnt += 2·q_m8 + n0 - n1.
    - Else:
      - out = {0, q_m8, q_m[7:0]}.
      - cnt += n1 - n0 - 2·~q_m8.
- cnt is forced to 0 in every non-VIDEO slot.
- Syncs travel through the delay line with the data, so sync/data alignment is preserved.

## Timing
- Latency L = LA+2 cycles from input to out_tmds_*/out_de/out_period, in both modes.
- Structure: LA delay stages + stage A + stage B, all registered.
- Throughput: one pixel per pclk; no stalls, no handshake.
- Reset (asynchronous):
  - All delay stages clear (de = 0, syncs 0).
  - cnt = 0.
  - out_tmds_* = 1101010100.
  - out_de = 0.
  - out_period = 00.
- After rst_n release:
  - Outputs stay at control code 00 until real samples reach stage B, L cycles later.
  - Input active during reset is treated as preceded by blanking, so preamble/guard apply per the distance rule.
- Blanking shorter than LA: slots are classified only by distance j. A 3-slot gap with defaults gives 1 PREAMBLE + 2 GUARD.
- A 1-slot gap gives 1 GUARD, and cnt is reset in that slot.
- No trailing guard band; the slot after the last active pixel is CTRL.

## Test plan
- Reset:
  - Stimulus: rst_n low with random inputs, then release with blank = 1, hsync = 1, vsync = 0.
  - Response: all outputs 1101010100, period 00, de = 0 during reset and for L cycles.
  - Response: blue = 0010101011 from cycle L.
  - Mid-stream reset: outputs return to reset values asynchronously.
- DVI encode and disparity:
  - Stimulus: HDMI_MODE = 0, ≥12 blank cycles, then two pixels 0x00 on all channels.
  - Response: words 0100000000 then 1111111111 (cnt sequence -8 → +2); latency exactly 12.
- HDMI insertion:
  - Stimulus: 20 blank cycles (hsync = 0, vsync = 1), then 4 active pixels.
  - Preamble response: exactly 8 slots with green 0010101011, red 1101010100, blue 0101010100, period 01.
  - Guard response: then 2 slots with blue/red 1011001100, green 0100110011, period 10.
  - Video response: then 4 VIDEO slots with out_de = 1, period 11.
- Short blank:
  - Stimulus: HDMI, active / 3 blank / active.
  - Response: 1 PREAMBLE + 2 GUARD slots.
  - Stimulus: 1-blank gap.
  - Response: 1 GUARD slot.
- Disparity reset:
  - Stimulus: pixel 0x00 (cnt → -8), blank gap, then pixel 0x00 again.
  - Response: second active word is 0100000000, not 1111111111.
- Sync alignment:
  - Stimulus: toggle hsync during blanking.
  - Response: blue code changes exactly L cycles after the input edge.

Source files
------------

// File: rtl/tmds_video_encoder.sv
// tmds_video_encoder: three-channel pixel-rate TMDS encoder.
// HDMI mode inserts video preamble and leading guard band via look-ahead.
module tmds_video_encoder #(
  parameter int HDMI_MODE    = 1,
  parameter int PREAMBLE_LEN = 8,
  parameter int GUARD_LEN    = 2
) (
  input  logic       pclk,
  input  logic       rst_n,
  input  logic [7:0] in_vga_red,
  input  logic [7:0] in_vga_green,
  input  logic [7:0] in_vga_blue,
  input  logic       in_vga_blank,
  input  logic       in_vga_vsync,
  input  logic       in_vga_hsync,
  output logic [9:0] out_tmds_red,
  output logic [9:0] out_tmds_green,
  output logic [9:0] out_tmds_blue,
  output logic       out_de,
  output logic [1:0] out_period
);
  localparam int LA = PREAMBLE_LEN + GUARD_LEN;
  localparam bit HDMI = (HDMI_MODE != 0);
  localparam logic [9:0] C00 = 10'b1101010100;
  localparam logic [9:0] GB_RB = 10'b1011001100;
  localparam logic [9:0] GB_G = 10'b0100110011;

  typedef enum logic [1:0] {
    P_CTRL  = 2'b00,
    P_PRE   = 2'b01,
    P_GUARD = 2'b10,
    P_VIDEO = 2'b11
  } period_t;

  typedef struct packed {
    logic       de;
    logic       vs;
    logic       hs;
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } slot_t;

  function automatic logic [9:0] ctl(input logic [1:0] c);
    logic [9:0] w;
    unique case (c)
      2'b00:   w = 10'b1101010100;
      2'b01:   w = 10'b0010101011;
      2'b10:   w = 10'b0101010100;
      default: w = 10'b1010101011;
    endcase
    return w;
  endfunction

  function automatic logic [8:0] stage_a(input logic [7:0] d);
    logic [3:0] n1;
    logic       x;
    logic [8:0] q;
    n1 = 4'($countones(d));
    x = (n1 > 4'd4) || (n1 == 4'd4 && !d[0]);
    q = '0;
    q[0] = d[0];
    for (int i = 1; i < 8; i++)
      q[i] = x ? ~(q[i-1] ^ d[i]) : (q[i-1] ^ d[i]);
    q[8] = ~x;
    return q;
  endfunction

  // Returns {new_cnt, word}; diff is n1-n0 of q_m[7:0]
  function automatic logic [14:0] stage_b(
    input logic [8:0]        qm,
    input logic signed [4:0] cnt
  );
    logic [4:0]        ones;
    logic signed [4:0] diff;
    logic signed [4:0] c;
    logic [9:0]        w;
    ones = 5'($countones(qm[7:0]));
    diff = $signed({ones[3:0], 1'b0}) - 5'sd8;
    if (cnt == 5'sd0 || diff == 5'sd0) begin
      w = {~qm[8], qm[8], qm[8] ? qm[7:0] : ~qm[7:0]};
      c = qm[8] ? cnt + diff : cnt - diff;
    end else if (cnt[4] == diff[4]) begin
      w = {1'b1, qm[8], ~qm[7:0]};
      c = cnt - diff + (qm[8] ? 5'sd2 : 5'sd0);
    end else begin
      w = {1'b0, qm[8], qm[7:0]};
      c = cnt + diff - (qm[8] ? 5'sd0 : 5'sd2);
    end
    return {c, w};
  endfunction

  slot_t [LA:0] s;
  slot_t        din;

  assign din = {~in_vga_blank, in_vga_vsync, in_vga_hsync,
                in_vga_red, in_vga_green, in_vga_blue};

  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) s <= '0;
    else        s <= {s[LA-1:0], din};
  end

  // ahead[k-1]: pixel k slots after the one being encoded is active
  logic [LA-1:0] ahead;
  logic          hit_g, hit_p;
  period_t       per_nx;

  always_comb begin
    ahead = '0;
    for (int k = 1; k <= LA; k++) ahead[k-1] = s[LA-k].de;
  end

  assign hit_g = HDMI && !s[LA].de && (|ahead[GUARD_LEN-1:0]);
  assign hit_p = HDMI && !s[LA].de && !hit_g && (|ahead);

  always_comb begin
    per_nx = P_CTRL;
    unique case (1'b1)
      s[LA].de: per_nx = P_VIDEO;
      hit_g:    per_nx = P_GUARD;
      hit_p:    per_nx = P_PRE;
      default:  per_nx = P_CTRL;
    endcase
  end

  period_t    per_a;
  logic       vs_a, hs_a;
  logic [8:0] qm_r, qm_g, qm_b;

  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) begin
      per_a <= P_CTRL;
      vs_a  <= 1'b0;
      hs_a  <= 1'b0;
      qm_r  <= '0;
      qm_g  <= '0;
      qm_b  <= '0;
    end else begin
      per_a <= per_nx;
      vs_a  <= s[LA].vs;
      hs_a  <= s[LA].hs;
      qm_r  <= stage_a(s[LA].r);
      qm_g  <= stage_a(s[LA].g);
      qm_b  <= stage_a(s[LA].b);
    end
  end

  logic signed [4:0] cnt_r, cnt_g, cnt_b;
  logic signed [4:0] c_r, c_g, c_b;
  logic [9:0]        w_r, w_g, w_b;

  always_comb begin
    w_r = C00;
    w_g = C00;
    w_b = ctl({vs_a, hs_a});
    c_r = '0;
    c_g = '0;
    c_b = '0;
    unique case (per_a)
      P_VIDEO: begin
        {c_r, w_r} = stage_b(qm_r, cnt_r);
        {c_g, w_g} = stage_b(qm_g, cnt_g);
        {c_b, w_b} = stage_b(qm_b, cnt_b);
      end
      P_GUARD: begin
        w_r = GB_RB;
        w_g = GB_G;
        w_b = GB_RB;
      end
      P_PRE:   w_g = ctl(2'b01);
      default: ;
    endcase
  end

  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_r          <= '0;
      cnt_g          <= '0;
      cnt_b          <= '0;
      out_tmds_red   <= C00;
      out_tmds_green <= C00;
      out_tmds_blue  <= C00;
      out_de         <= 1'b0;
      out_period     <= 2'b00;
    end else begin
      cnt_r          <= c_r;
      cnt_g          <= c_g;
      cnt_b          <= c_b;
      out_tmds_red   <= w_r;
      out_tmds_green <= w_g;
      out_tmds_blue  <= w_b;
      out_de         <= (per_a == P_VIDEO);
      out_period     <= per_a;
    end
  end

endmodule

// File: tb/tb_tmds_video_encoder.sv
// tb_tmds_video_encoder: HDMI and DVI instances against a
// slot-history reference model, plus directed boundary checks.
module tb_tmds_video_encoder;
  localparam int PRE = 8;
  localparam int GRD = 2;
  localparam int LA = PRE + GRD;
  localparam int L = LA + 2;
  localparam int NMAX = 16384;
  localparam logic [9:0] C00 = 10'b1101010100;
  localparam logic [9:0] C01 = 10'b0010101011;
  localparam logic [9:0] C10 = 10'b0101010100;
  localparam logic [9:0] C11 = 10'b1010101011;
  localparam logic [9:0] GB = 10'b1011001100;
  localparam logic [9:0] GG = 10'b0100110011;
  localparam logic [9:0] Z0 = 10'b0100000000;
  localparam logic [9:0] Z1 = 10'b1111111111;
  localparam logic [32:0] RST_VEC = {1'b0, 2'b00, C00, C00, C00};

  typedef struct packed {
    logic       de;
    logic       vs;
    logic       hs;
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } samp_t;

  logic       pclk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] r = '0, g = '0, b = '0;
  logic       blank = 1'b1, vs = 1'b0, hs = 1'b0;
  logic [9:0] h_r, h_g, h_b, d_r, d_g, d_b;
  logic       h_de, d_de;
  logic [1:0] h_per, d_per;

  samp_t       hist  [NMAX];
  logic [32:0] log_h [NMAX];
  logic [32:0] log_d [NMAX];
  int          cnt_m [2][3];
  int          edge_n = 0;
  int          checks = 0;
  int          failures = 0;

  always #5 pclk = ~pclk;

  tmds_video_encoder #(.HDMI_MODE(1), .PREAMBLE_LEN(PRE), .GUARD_LEN(GRD)) u_hdmi (
    .pclk(pclk), .rst_n(rst_n),
    .in_vga_red(r), .in_vga_green(g), .in_vga_blue(b),
    .in_vga_blank(blank), .in_vga_vsync(vs), .in_vga_hsync(hs),
    .out_tmds_red(h_r), .out_tmds_green(h_g), .out_tmds_blue(h_b),
    .out_de(h_de), .out_period(h_per)
  );

  tmds_video_encoder #(.HDMI_MODE(0), .PREAMBLE_LEN(PRE), .GUARD_LEN(GRD)) u_dvi (
    .pclk(pclk), .rst_n(rst_n),
    .in_vga_red(r), .in_vga_green(g), .in_vga_blue(b),
    .in_vga_blank(blank), .in_vga_vsync(vs), .in_vga_hsync(hs),
    .out_tmds_red(d_r), .out_tmds_green(d_g), .out_tmds_blue(d_b),
    .out_de(d_de), .out_period(d_per)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s edge=%0d got=%h exp=%h", tag, edge_n, got, exp);
    end
  endtask

  function automatic logic [9:0] ctl(input logic [1:0] c);
    case (c)
      2'd0:    return C00;
      2'd1:    return C01;
      2'd2:    return C10;
      default: return C11;
    endcase
  endfunction

  function automatic samp_t get(input int n);
    if (n < 1 || n > edge_n) return '0;
    return hist[n];
  endfunction

  // 0 ctrl, 1 preamble, 2 guard, 3 video
  function automatic int slot_kind(input int n, input bit hdmi);
    samp_t s;
    int    j;
    j = 0;
    s = get(n);
    if (s.de) return 3;
    for (int k = LA; k >= 1; k--) begin
      s = get(n + k);
      if (s.de) j = k;
    end
    if (j == 0 || !hdmi) return 0;
    return (j <= GRD) ? 2 : 1;
  endfunction

  task automatic enc(input logic [7:0] d, input int cin,
                     output logic [9:0] w, output int cout);
    int         n1, q1, diff, q8;
    logic       x;
    logic [8:0] q;
    n1 = 0;
    q1 = 0;
    for (int i = 0; i < 8; i++) n1 += int'(d[i]);
    x = (n1 > 4) || (n1 == 4 && d[0] == 1'b0);
    q = '0;
    q[0] = d[0];
    for (int i = 1; i < 8; i++) q[i] = x ? ~(q[i-1] ^ d[i]) : (q[i-1] ^ d[i]);
    q[8] = ~x;
    q8 = int'(q[8]);
    for (int i = 0; i < 8; i++) q1 += int'(q[i]);
    diff = 2 * q1 - 8;
    if (cin == 0 || diff == 0) begin
      w = {~q[8], q[8], q[8] ? q[7:0] : ~q[7:0]};
      cout = (q8 == 1) ? cin + diff : cin - diff;
    end else if ((cin > 0 && diff > 0) || (cin < 0 && diff < 0)) begin
      w = {1'b1, q[8], ~q[7:0]};
      cout = cin + 2 * q8 - diff;
    end else begin
      w = {1'b0, q[8], q[7:0]};
      cout = cin + diff - 2 * (1 - q8);
    end
  endtask

  task automatic model_vec(input int m, output logic [32:0] v);
    samp_t      s;
    int         k;
    logic [9:0] w [3];
    logic [7:0] px [3];
    if (!rst_n) begin
      for (int c = 0; c < 3; c++) cnt_m[m][c] = 0;
      v = RST_VEC;
    end else begin
      s = get(edge_n - L);
      k = slot_kind(edge_n - L, m == 0);
      px[0] = s.b;
      px[1] = s.g;
      px[2] = s.r;
      w[0] = ctl({s.vs, s.hs});
      w[1] = C00;
      w[2] = C00;
      if (k == 3) begin
        for (int c = 0; c < 3; c++) enc(px[c], cnt_m[m][c], w[c], cnt_m[m][c]);
      end else begin
        for (int c = 0; c < 3; c++) cnt_m[m][c] = 0;
        if (k == 2) begin
          w[0] = GB;
          w[1] = GG;
          w[2] = GB;
        end else if (k == 1) begin
          w[1] = C01;
        end
      end
      v = {k == 3, 2'(k), w[2], w[1], w[0]};
    end
  endtask

  task automatic tick();
    logic [32:0] ev;
    @(posedge pclk);
    edge_n++;
    hist[edge_n] = rst_n ? {~blank, vs, hs, r, g, b} : '0;
    #1;
    log_h[edge_n] = {h_de, h_per, h_r, h_g, h_b};
    log_d[edge_n] = {d_de, d_per, d_r, d_g, d_b};
    model_vec(0, ev);
    check("hdmi_model", 64'(log_h[edge_n]), 64'(ev));
    model_vec(1, ev);
    check("dvi_model", 64'(log_d[edge_n]), 64'(ev));
  endtask

  task automatic idle(input int n);
    blank = 1'b1;
    repeat (n) tick();
  endtask

  task automatic play(input string pat, input bit zero_px, output int first_a);
    byte ch;
    first_a = -1;
    for (int i = 0; i < pat.len(); i++) begin
      ch = pat[i];
      blank = (ch != 8'h41);
      if (!blank) begin
        r = zero_px ? 8'h00 : 8'($urandom);
        g = zero_px ? 8'h00 : 8'($urandom);
        b = zero_px ? 8'h00 : 8'($urandom);
      end
      tick();
      if (!blank && first_a < 0) first_a = edge_n;
    end
  endtask

  function automatic int count_per(input bit dvi, input int lo, input int hi,
                                   input logic [1:0] p);
    int c;
    c = 0;
    for (int e = lo; e <= hi; e++) begin
      if (dvi ? (log_d[e][31:30] == p) : (log_h[e][31:30] == p)) c++;
    end
    return c;
  endfunction

  task automatic async_reset();
    rst_n = 1'b0;
    #2;
    check("arst_hdmi", 64'({h_de, h_per, h_r, h_g, h_b}), 64'(RST_VEC));
    check("arst_dvi", 64'({d_de, d_per, d_r, d_g, d_b}), 64'(RST_VEC));
    idle(20);
    rst_n = 1'b1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog edge=%0d", edge_n);
    $fatal(1, "watchdog");
  end

  initial begin
    int a, bl, al;
    for (int m = 0; m < 2; m++)
      for (int c = 0; c < 3; c++) cnt_m[m][c] = 0;

    rst_n = 1'b0;
    for (int i = 0; i < 20; i++) begin
      r = 8'($urandom);
      g = 8'($urandom);
      b = 8'($urandom);
      blank = 1'($urandom);
      hs = 1'($urandom);
      vs = 1'($urandom);
      tick();
    end
    blank = 1'b1;
    hs = 1'b1;
    vs = 1'b0;
    rst_n = 1'b1;
    a = edge_n;
    repeat (L + 3) tick();
    check("rst_hold_L", 64'(log_h[a+L]), 64'(RST_VEC));
    check("rst_first", 64'(log_h[a+L+1]), 64'({1'b0, 2'b00, C00, C00, C01}));

    hs = 1'b0;
    idle(14);
    play("AA", 1'b1, a);
    idle(16);
    check("dvi_lat", 64'(log_d[a+L-1][32]), 64'(1'b0));
    check("dvi_zero1", 64'(log_d[a+L]), 64'({1'b1, 2'b11, Z0, Z0, Z0}));
    check("dvi_zero2", 64'(log_d[a+L+1]), 64'({1'b1, 2'b11, Z1, Z1, Z1}));

    hs = 1'b0;
    vs = 1'b1;
    idle(20);
    play("AAAA", 1'b0, a);
    idle(20);
    check("ins_pre", 64'(count_per(0, a + 1, a + 16, 2'b01)), 64'(8));
    check("ins_guard", 64'(count_per(0, a + 1, a + 16, 2'b10)), 64'(2));
    check("ins_video", 64'(count_per(0, a + 1, a + 16, 2'b11)), 64'(4));
    check("ins_dvi", 64'(count_per(1, a + 1, a + 16, 2'b01) +
                         count_per(1, a + 1, a + 16, 2'b10)), 64'(0));
    check("pre_first", 64'(log_h[a+2]), 64'({1'b0, 2'b01, C00, C01, C10}));
    check("pre_last", 64'(log_h[a+9]), 64'({1'b0, 2'b01, C00, C01, C10}));
    check("guard_word", 64'(log_h[a+10]), 64'({1'b0, 2'b10, GB, GG, GB}));
    check("video_de", 64'(log_h[a+12][32]), 64'(1'b1));

    vs = 1'b0;
    idle(20);
    play("AABBBAA", 1'b0, a);
    idle(20);
    check("gap3_pre", 64'(count_per(0, a + L + 2, a + L + 6, 2'b01)), 64'(1));
    check("gap3_guard", 64'(count_per(0, a + L + 2, a + L + 6, 2'b10)), 64'(2));
    check("gap3_video", 64'(count_per(0, a + L + 2, a + L + 6, 2'b11)), 64'(2));

    idle(20);
    play("AABAA", 1'b0, a);
    idle(20);
    check("gap1_guard", 64'(count_per(0, a + L + 2, a + L + 4, 2'b10)), 64'(1));
    check("gap1_pre", 64'(count_per(0, a + L + 2, a + L + 4, 2'b01)), 64'(0));

    idle(20);
    play("ABA", 1'b1, a);
    idle(20);
    check("disp_first", 64'(log_h[a+L][29:0]), 64'({Z0, Z0, Z0}));
    check("disp_gap", 64'(log_h[a+L+1][31:30]), 64'(2'b10));
    check("disp_hdmi", 64'(log_h[a+L+2][29:0]), 64'({Z0, Z0, Z0}));
    check("disp_dvi", 64'(log_d[a+L+2][29:0]), 64'({Z0, Z0, Z0}));

    hs = 1'b0;
    vs = 1'b0;
    idle(20);
    hs = 1'b1;
    tick();
    a = edge_n;
    idle(20);
    check("sync_before", 64'(log_d[a+L-1][9:0]), 64'(C00));
    check("sync_edge", 64'(log_d[a+L][9:0]), 64'(C01));
    check("sync_hdmi", 64'(log_h[a+L][9:0]), 64'(C01));

    for (int seg = 0; seg < 120; seg++) begin
      bl = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 4))
                                       : int'($urandom_range(5, 25));
      blank = 1'b1;
      for (int i = 0; i < bl; i++) begin
        if ($urandom_range(0, 3) == 0) hs = ~hs;
        if ($urandom_range(0, 7) == 0) vs = ~vs;
        tick();
      end
      al = int'($urandom_range(1, 30));
      for (int i = 0; i < al; i++) begin
        blank = 1'b0;
        case ($urandom_range(0, 5))
          0:       {r, g, b} = '0;
          1:       {r, g, b} = '1;
          default: {r, g, b} = 24'($urandom);
        endcase
        tick();
        if (seg == 60 && i == 0) async_reset();
      end
    end
    idle(L + 2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
